// File: rtl/delay_pipe_pkg.sv
// delay_pipe_pkg
//   Shared helpers for the delay-pipe response buffer.
//   cw(depth)             : width needed to hold a count of 0..depth
//   inc_and_clip(v,limit) : increment with wrap limit-1 -> 0. Works for
//                           non-power-of-two limits.
package delay_pipe_pkg;

   function automatic int cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned inc_and_clip(input int unsigned v,
                                                input int unsigned limit);
      return (v >= limit - 1) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/delay_pipe_credit_cnt.sv
// delay_pipe_credit_cnt
//   Free-credit counter. Resets to DEPTH. One credit is taken per issue
//   and one is given back per downstream pop. Take and give together
//   cancel out.
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   take      : issue accepted this cycle
//   give      : item popped downstream this cycle
//   credit_r  : current free credits (registered)
//   avail     : credit_r != 0, a decode of the flop only
module delay_pipe_credit_cnt
   import delay_pipe_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int CW = cw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          take,
   input  logic          give,
   output logic [CW-1:0] credit_r,
   output logic          avail
);

   logic [CW-1:0] credit_q;
   logic [CW-1:0] credit_d;

   always_comb begin
      credit_d = credit_q;
      if (take && !give) begin
         credit_d = credit_q - CW'(1);
      end else if (give && !take) begin
         credit_d = credit_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_q <= CW'(DEPTH);
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit_r = credit_q;
   assign avail    = (credit_q != '0);

endmodule

// File: rtl/delay_pipe_rsp_buf.sv
// delay_pipe_rsp_buf
//   Consumer end of a fixed-latency N-cycle delay pipe. Every issue into
//   the pipe reserves a FIFO slot through a credit, so returning data
//   (pipe_vld, no ready) always finds room. Stored items drain downstream
//   under valid/ready backpressure.
// Handshake: a transfer happens on a clock edge where valid and ready are
//   both high. The issue side transfers on issue_vld & issue_rdy, and
//   issue_vld may only be raised while issue_rdy is high. The output side
//   transfers on out_vld & out_rdy. Once out_vld is high it stays high,
//   with out_dat stable, until that transfer happens.
// Ports
//   issue_vld/issue_rdy : launch into the delay pipe / credit available
//   pipe_vld/pipe_dat   : item returning from the delay pipe
//   out_vld/out_dat/out_rdy : FIFO head, downstream valid/ready
//   credit_r            : free credits
// Configuration macro
//   DELAY_PIPE_RSP_BYPASS_EN : when the FIFO is empty, a returning item is
//   presented on out_* in the same cycle. If out_rdy is also high, the
//   item is consumed without being written to the FIFO.
module delay_pipe_rsp_buf
   import delay_pipe_pkg::*;
#(
   parameter int N     = 5,
   parameter int W     = 32,
   parameter int DEPTH = 8,
   localparam int CW   = cw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_vld,
   output logic          issue_rdy,
   input  logic          pipe_vld,
   input  logic [W-1:0]  pipe_dat,
   output logic          out_vld,
   output logic [W-1:0]  out_dat,
   input  logic          out_rdy,
   output logic [CW-1:0] credit_r
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] inflight_q, inflight_d;

   logic fifo_vld, wr_en, rd_en, pop, accept, bypass_pop;

   assign fifo_vld = (occ_q != '0);
   assign accept   = issue_vld & issue_rdy;

`ifdef DELAY_PIPE_RSP_BYPASS_EN
   assign out_vld    = fifo_vld | pipe_vld;
   assign out_dat    = fifo_vld ? mem_q[rd_ptr_q] : pipe_dat;
   assign bypass_pop = !fifo_vld & pipe_vld & out_rdy;
`else
   assign out_vld    = fifo_vld;
   assign out_dat    = mem_q[rd_ptr_q];
   assign bypass_pop = 1'b0;
`endif

   assign pop   = out_vld & out_rdy;
   assign rd_en = fifo_vld & out_rdy;
   // A bypassed item is consumed directly and never occupies a slot.
   assign wr_en = pipe_vld & ~bypass_pop;

   delay_pipe_credit_cnt #(.DEPTH(DEPTH)) u_credit (
      .clk      (clk),
      .rst      (rst),
      .take     (accept),
      .give     (pop),
      .credit_r (credit_r),
      .avail    (issue_rdy)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      inflight_d = inflight_q;
      if (wr_en) wr_ptr_d = PW'(inc_and_clip(32'(wr_ptr_q), DEPTH));
      if (rd_en) rd_ptr_d = PW'(inc_and_clip(32'(rd_ptr_q), DEPTH));
      case ({wr_en, rd_en})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
      // Items launched but not yet returned; used only by the checks below.
      case ({accept, pipe_vld})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         inflight_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= pipe_dat;
   end

   a_issue_legal: assert property (@(posedge clk) disable iff (rst)
      issue_vld |-> issue_rdy);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && occ_q == CW'(DEPTH)));
   a_credit_sum: assert property (@(posedge clk) disable iff (rst)
      (32'(credit_r) + 32'(occ_q) + 32'(inflight_q)) == DEPTH);
   a_inflight_max: assert property (@(posedge clk) disable iff (rst)
      32'(inflight_q) <= N);

endmodule

// File: tb/tb_delay_pipe_rsp_buf.sv
module tb_delay_pipe_rsp_buf;
  localparam int N   = 5;
  localparam int W   = 32;
  localparam int D8  = 8;
  localparam int D6  = 6;
  localparam int CW8 = 4;
  localparam int CW6 = 3;
`ifdef DELAY_PIPE_RSP_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int           c;
    logic [W-1:0] d;
  } ret_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus, routed to whichever instance is selected
  logic         use6 = 1'b0;
  logic         issue_vld_c = 1'b0;
  logic         pipe_vld_c = 1'b0;
  logic         out_rdy_c = 1'b0;
  logic [W-1:0] pipe_dat_c = '0;

  logic           issue_vld8, pipe_vld8, out_rdy8, issue_rdy8, out_vld8;
  logic [W-1:0]   out_dat8;
  logic [CW8-1:0] credit8;
  logic           issue_vld6, pipe_vld6, out_rdy6, issue_rdy6, out_vld6;
  logic [W-1:0]   out_dat6;
  logic [CW6-1:0] credit6;

  assign issue_vld8 = !use6 & issue_vld_c;
  assign pipe_vld8  = !use6 & pipe_vld_c;
  assign out_rdy8   = !use6 & out_rdy_c;
  assign issue_vld6 = use6 & issue_vld_c;
  assign pipe_vld6  = use6 & pipe_vld_c;
  assign out_rdy6   = use6 & out_rdy_c;

  logic         cur_issue_rdy, cur_out_vld;
  logic [W-1:0] cur_out_dat;
  logic [31:0]  cur_credit;
  assign cur_issue_rdy = use6 ? issue_rdy6 : issue_rdy8;
  assign cur_out_vld   = use6 ? out_vld6 : out_vld8;
  assign cur_out_dat   = use6 ? out_dat6 : out_dat8;
  assign cur_credit    = use6 ? 32'(credit6) : 32'(credit8);

  delay_pipe_rsp_buf #(.N(N), .W(W), .DEPTH(D8)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld8), .issue_rdy(issue_rdy8),
    .pipe_vld(pipe_vld8), .pipe_dat(pipe_dat_c),
    .out_vld(out_vld8), .out_dat(out_dat8), .out_rdy(out_rdy8),
    .credit_r(credit8)
  );

  delay_pipe_rsp_buf #(.N(N), .W(W), .DEPTH(D6)) dut6 (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld6), .issue_rdy(issue_rdy6),
    .pipe_vld(pipe_vld6), .pipe_dat(pipe_dat_c),
    .out_vld(out_vld6), .out_dat(out_dat6), .out_rdy(out_rdy6),
    .credit_r(credit6)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  ret_t         ret_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           pop_cnt = 0;
  int           cyc = 0;
  logic [W-1:0] next_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: inputs change 1 time unit after the rising edge.
  // The upstream pipe model returns each issued item exactly N cycles later.
  task automatic drive(input logic want, input logic rdy);
    @(posedge clk);
    #1;
    cyc++;
    pipe_vld_c = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].c == cyc) begin
      pipe_vld_c = 1'b1;
      pipe_dat_c = ret_q[0].d;
      void'(ret_q.pop_front());
    end
    out_rdy_c   = rdy;
    issue_vld_c = want & cur_issue_rdy;
    if (issue_vld_c) begin
      ret_q.push_back('{cyc + N, next_dat});
      exp_q.push_back(next_dat);
      next_dat = next_dat + 1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // monitor: every downstream transfer is checked against the queue head
  always @(negedge clk) begin
    if (!rst && cur_out_vld && out_rdy_c) begin
      n_checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_dat: got 0x%0h with scoreboard empty at %0t", cur_out_dat, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (cur_out_dat !== e) begin
          n_fail++;
          $display("FAIL out_dat: got 0x%0h expected 0x%0h at %0t", cur_out_dat, e, $time);
        end
      end
    end
  end

  initial begin
    int n_acc;
    int p0;
    int issued;

    // reset values
    repeat (2) @(posedge clk);
    sample();
    chk("rst_credit", cur_credit, 32'd8);
    chk("rst_issue_rdy", 32'(cur_issue_rdy), 32'd1);
    chk("rst_out_vld", 32'(cur_out_vld), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: single issue, return after N cycles with 0xA5
    next_dat = 32'hA5;
    drive(1'b1, 1'b1);
    sample();
    chk("t1_credit_t0", cur_credit, 32'd8);
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b1);
      sample();
      chk("t1_out_vld", 32'(cur_out_vld), 32'(k == 5 + LAT));
      chk("t1_credit", cur_credit, (k <= 5 + LAT) ? 32'd7 : 32'd8);
    end

    // 2: fill with out_rdy low
    next_dat = 32'h200;
    n_acc = 0;
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, 1'b0);
      if (issue_vld_c) n_acc++;
    end
    sample();
    chk("t2_accepts", 32'(n_acc), 32'd8);
    chk("t2_credit", cur_credit, 32'd0);
    chk("t2_issue_rdy", 32'(cur_issue_rdy), 32'd0);
    chk("t2_out_vld", 32'(cur_out_vld), 32'd1);
    chk("t2_occ", 32'(dut.occ_q), 32'd8);
    chk("t2_head", cur_out_dat, 32'h200);

    // 3: drain with issue held -> one item per cycle sustained
    p0 = pop_cnt;
    for (int k = 0; k < 30; k++) drive(1'b1, 1'b1);
    sample();
    chk("t3_throughput", 32'(pop_cnt - p0), 32'd30);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1);
    sample();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_credit", cur_credit, 32'd8);
    chk("t3_out_vld", 32'(cur_out_vld), 32'd0);

    // 4: accept + pop at credit 3, write + pop with one stored item
    next_dat = 32'h300;
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    sample();
    chk("t4_credit_pre", cur_credit, 32'd3);
    chk("t4_pipe_vld", 32'(pipe_vld_c), 32'd1);
    chk("t4_occ_pre", 32'(dut.occ_q), 32'd1);
    drive(1'b0, 1'b0);
    sample();
    chk("t4_credit_post", cur_credit, 32'd3);
    chk("t4_occ_post", 32'(dut.occ_q), 32'd1);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1);
    sample();
    chk("t4_credit_end", cur_credit, 32'd8);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset with 4 in flight and 3 stored
    next_dat = 32'h400;
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    @(posedge clk);
    #1;
    pipe_vld_c  = 1'b0;
    issue_vld_c = 1'b0;
    chk("t6_occ_pre", 32'(dut.occ_q), 32'd3);
    chk("t6_inflight_pre", 32'(ret_q.size()), 32'd4);
    rst = 1'b1;
    #1;
    chk("t6_out_vld_async", 32'(cur_out_vld), 32'd0);
    chk("t6_credit_async", cur_credit, 32'd8);
    chk("t6_issue_rdy_async", 32'(cur_issue_rdy), 32'd1);
    ret_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p0 = pop_cnt;
    next_dat = 32'h500;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1);
    sample();
    chk("t6_resume_pops", 32'(pop_cnt - p0), 32'd3);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_credit_end", cur_credit, 32'd8);

    // 5: DEPTH=6 instance, 20 items through wrapping pointers
    use6 = 1'b1;
    next_dat = 32'h600;
    p0 = pop_cnt;
    issued = 0;
    for (int k = 0; k < 70; k++) begin
      drive(issued < 20, (k % 4) != 3);
      if (issue_vld_c) issued++;
    end
    for (int k = 0; k < 15; k++) drive(1'b0, 1'b1);
    sample();
    chk("t5_issued", 32'(issued), 32'd20);
    chk("t5_pops", 32'(pop_cnt - p0), 32'd20);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_credit", cur_credit, 32'd6);
    chk("t5_wr_ptr", 32'(dut6.wr_ptr_q), 32'd2);
    chk("t5_rd_ptr", 32'(dut6.rd_ptr_q), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
